// File: rtl/sub16_seq_pkg.sv
// sub16_seq_pkg: shared state encoding and sizing constants for the sequential subtractor.
//   state_e   : IDLE / CALC / DONE controller states
//   WIDTH_DEF : default operand width
//   SLICE_DEF : default bits processed per clock
//   NSLICE    : slices per operation at the defaults
//   CNT_W     : slice index width at the defaults
package sub16_seq_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;
   localparam int WIDTH_DEF = 16;
   localparam int SLICE_DEF = 4;
   localparam int NSLICE    = WIDTH_DEF / SLICE_DEF;
   localparam int CNT_W     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/sub16_seq_sub_slice4.sv
// sub_slice4: combinational 4-bit carry-lookahead adder slice.
//   x  : first addend (minuend slice)
//   y  : second addend (already-inverted subtrahend slice)
//   ci : carry in (inverted borrow)
//   s  : 4-bit sum
//   co : carry out (inverted borrow out)
module sub_slice4 (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [3:0] g, p;
   logic [3:1] c;
   assign g = x & y;
   assign p = x ^ y;
   assign c[1] = g[0] | (p[0] & ci);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
   assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (&p & ci);
   assign s    = p ^ {c, ci};
endmodule

// File: rtl/sub16_seq.sv
// sub16_seq: multi-cycle subtractor d = a - b - bin, one SLICE-bit slice per clock, LSB first.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : request; accepted only in IDLE
//   a, b, bin       : operands, latched on the accept edge
//   busy            : high whenever not IDLE
//   done            : one-cycle pulse, results valid while high
//   d, bout, ovf, zero : difference, borrow out, signed overflow, zero flag
module sub16_seq
   import sub16_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SLICE = SLICE_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);
   localparam int NS = WIDTH / SLICE;
   localparam int CW = cnt_width(NS);
   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, d_q, d_new;
   logic [CW-1:0]    idx_q;
   logic             carry_q, bout_q, ovf_q, zero_q;
   logic [SLICE-1:0] xs, ys_n, s;
   logic             co, last;
   // One lookahead slice is shared across all slice positions; the index picks the operands.
   assign xs   = a_q[idx_q*SLICE +: SLICE];
   assign ys_n = ~b_q[idx_q*SLICE +: SLICE];
   assign last = idx_q == CW'(NS - 1);
   sub_slice4 u_slice (
      .x  (xs),
      .y  (ys_n),
      .ci (carry_q),
      .s  (s),
      .co (co)
   );
   always_comb begin
      d_new = d_q;
      d_new[idx_q*SLICE +: SLICE] = s;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end
   always_comb begin
      state_d = (state_q == IDLE) ? (start ? CALC : IDLE)
              : (state_q == CALC) ? (last ? DONE : CALC)
              : IDLE;
   end
   always_comb begin
      busy = state_q != IDLE;
      done = state_q == DONE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         d_q     <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else if (state_q == IDLE && start) begin
         a_q     <= a;
         b_q     <= b;
         carry_q <= ~bin;
         idx_q   <= '0;
      end else if (state_q == CALC) begin
         d_q     <= d_new;
         carry_q <= co;
         idx_q   <= idx_q + 1'b1;
         if (last) begin
            // Carry out of an adder fed with ~b is the inverse of the borrow.
            bout_q <= ~co;
            ovf_q  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_new[WIDTH-1] != a_q[WIDTH-1]);
            zero_q <= d_new == '0;
         end
      end
   end
   assign d    = d_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;
   assign zero = zero_q;
endmodule
